// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared constants and decode for the iterative ALU.
//   funct3/funct7 codes, FSM state encodings, the internal op enum and the
//   decode function that maps (alu_en, imm, funct3, funct7) to an op.
package alu_iter_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  localparam logic [6:0] FUNCT7_ZBB = 7'b0000101;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_XOR, OP_OR, OP_AND, OP_MIN, OP_MINU, OP_MAX, OP_MAXU
  } alu_op_e;

  // wide=1 for XLEN=64: funct7[0] carries shamt[5], so it is excluded from
  // the alternate-op compare.
  function automatic alu_op_e decode_op(input logic alu_en, input logic imm,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic wide, input logic zbb_en);
    logic    alt;
    logic    zbb;
    alu_op_e op;
    alt = wide ? (f7[6:1] == FUNCT7_ALT[6:1]) : (f7 == FUNCT7_ALT);
    zbb = zbb_en && (f7 == FUNCT7_ZBB) && !imm;
    op  = OP_ADD;
    if (alu_en) begin
      case (f3)
        F3_ADD:  op = (alt && !imm) ? OP_SUB : OP_ADD;
        F3_SLL:  op = OP_SLL;
        F3_SLT:  op = OP_SLT;
        F3_SLTU: op = OP_SLTU;
        F3_XOR:  op = zbb ? OP_MIN  : OP_XOR;
        F3_SRL:  op = zbb ? OP_MINU : (alt ? OP_SRA : OP_SRL);
        F3_OR:   op = zbb ? OP_MAX  : OP_OR;
        F3_AND:  op = zbb ? OP_MAXU : OP_AND;
        default: op = OP_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if: request/response bundle between the execute stage and alu_iter.
//   i_valid/o_ready request handshake, i_flush kill, decode fields, operands,
//   o_valid result pulse, o_busy multi-cycle indicator, o_alu_out result.
//   master = requester (pipeline), slave = alu_iter.
interface alu_iter_if #(parameter int XLEN = 32);
  logic            i_valid;
  logic            i_flush;
  logic            i_alu_en;
  logic            i_alu_imm;
  logic [2:0]      i_funct3;
  logic [6:0]      i_funct7;
  logic [XLEN-1:0] i_in_a;
  logic [XLEN-1:0] i_in_b;
  logic            o_ready;
  logic            o_valid;
  logic            o_busy;
  logic [XLEN-1:0] o_alu_out;

  modport master (
    output i_valid, i_flush, i_alu_en, i_alu_imm, i_funct3, i_funct7, i_in_a, i_in_b,
    input  o_ready, o_valid, o_busy, o_alu_out
  );

  modport slave (
    input  i_valid, i_flush, i_alu_en, i_alu_imm, i_funct3, i_funct7, i_in_a, i_in_b,
    output o_ready, o_valid, o_busy, o_alu_out
  );
endinterface

// File: rtl/alu_iter_shift_step.sv
// alu_iter_shift_step: combinational shift of data by 0..STEP bits.
//   data     : value to shift
//   amount   : shift distance, never above STEP (and below XLEN)
//   dir_left : 1 = logical left, 0 = right
//   fill     : bit shifted in from the top on right shifts (sign for SRA)
//   result   : shifted value
module alu_iter_shift_step #(
  parameter int XLEN  = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir_left,
  input  logic             fill,
  output logic [XLEN-1:0]  result
);
  logic [XLEN-1:0] fill_mask;
  logic [XLEN-1:0] right;

  always_comb begin
    // top 'amount' bits set; or-ed in only when the fill bit is 1
    fill_mask = ~({XLEN{1'b1}} >> amount);
    right     = (data >> amount) | (fill ? fill_mask : '0);
    result    = dir_left ? (data << amount) : right;
  end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: integer ALU with registered result and an iterative shifter.
//   i_clk_n : clock, rising-edge active
//   i_rst   : asynchronous active-high reset
//   bus     : alu_iter_if slave (request fields, handshake, result)
// Non-shift ops complete in one cycle; shifts move at most SHIFT_STEP bits
// per cycle, holding o_ready low while in SHIFT.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4,
  parameter bit ZBB_EN     = 1'b0
) (
  input  logic       i_clk_n,
  input  logic       i_rst,
  alu_iter_if.slave  bus
);
  localparam int SHW   = $clog2(XLEN);
  localparam int AW    = SHW + 1;
  localparam int AMT_W = $clog2(SHIFT_STEP + 1);
  localparam logic [AW-1:0] STEP_AW = AW'(SHIFT_STEP);

  logic [0:0]      state;
  logic [AW-1:0]   rem;
  logic [XLEN-1:0] acc;
  logic            acc_left;
  logic            acc_fill;
  logic [XLEN-1:0] alu_out;
  logic            out_valid;

  alu_op_e         op;
  logic            ready;
  logic            accept;
  logic            is_shift;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] alu_res;
  logic            sh_busy;
  logic [XLEN-1:0] sh_data;
  logic            sh_left;
  logic            sh_fill;
  logic [AW-1:0]   sh_total;
  logic [AW-1:0]   sh_amt;
  logic [AW-1:0]   sh_rem_next;
  logic [XLEN-1:0] sh_out;

  assign a        = bus.i_in_a;
  assign b        = bus.i_in_b;
  assign op       = decode_op(bus.i_alu_en, bus.i_alu_imm, bus.i_funct3, bus.i_funct7,
                              XLEN == 64, ZBB_EN);
  assign ready    = (state == ST_IDLE) && !i_rst;
  assign accept   = bus.i_valid && ready && !bus.i_flush;
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign lt_s     = $signed(a) < $signed(b);
  assign lt_u     = a < b;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a + ~b + XLEN'(1);
      OP_SLT:  alu_res = XLEN'(lt_s);
      OP_SLTU: alu_res = XLEN'(lt_u);
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_MIN:  alu_res = lt_s ? a : b;
      OP_MINU: alu_res = lt_u ? a : b;
      OP_MAX:  alu_res = lt_s ? b : a;
      OP_MAXU: alu_res = lt_u ? b : a;
      default: alu_res = '0;
    endcase
  end

  // One shifter serves both the accept-cycle step (fresh operands) and the
  // SHIFT-state steps (latched accumulator and direction/fill).
  always_comb begin
    sh_busy     = (state == ST_SHIFT);
    sh_data     = sh_busy ? acc : a;
    sh_left     = sh_busy ? acc_left : (op == OP_SLL);
    sh_fill     = sh_busy ? acc_fill : ((op == OP_SRA) && a[XLEN-1]);
    sh_total    = sh_busy ? rem : {1'b0, b[SHW-1:0]};
    sh_amt      = (sh_total > STEP_AW) ? STEP_AW : sh_total;
    sh_rem_next = sh_total - sh_amt;
  end

  alu_iter_shift_step #(.XLEN(XLEN), .STEP(SHIFT_STEP)) u_shift_step (
    .data     (sh_data),
    .amount   (sh_amt[AMT_W-1:0]),
    .dir_left (sh_left),
    .fill     (sh_fill),
    .result   (sh_out)
  );

  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      rem       <= '0;
      acc       <= '0;
      acc_left  <= 1'b0;
      acc_fill  <= 1'b0;
      alu_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (bus.i_flush) begin
        state <= ST_IDLE;
        rem   <= '0;
      end else if (state == ST_IDLE) begin
        if (accept) begin
          if (is_shift && (sh_rem_next != '0)) begin
            acc      <= sh_out;
            rem      <= sh_rem_next;
            acc_left <= sh_left;
            acc_fill <= sh_fill;
            state    <= ST_SHIFT;
          end else begin
            alu_out   <= is_shift ? sh_out : alu_res;
            out_valid <= 1'b1;
          end
        end
      end else begin
        acc <= sh_out;
        rem <= sh_rem_next;
        if (sh_rem_next == '0) begin
          alu_out   <= sh_out;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
      end
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_busy    = (state == ST_SHIFT);
  assign bus.o_valid   = out_valid;
  assign bus.o_alu_out = alu_out;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter.
//   dut32: XLEN=32, SHIFT_STEP=4, ZBB_EN=1
//   dut64: XLEN=64, SHIFT_STEP=64, ZBB_EN=0
// Expected result and due cycle are queued at drive time and popped when
// o_valid is seen.
module tb_alu_iter;
  logic clk   = 1'b0;
  logic rst32 = 1'b0;
  logic rst64 = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  logic [63:0] exp_q32[$];
  logic [63:0] exp_q64[$];
  int          due_q32[$];
  int          due_q64[$];
  logic [63:0] last32 = '0;
  logic [63:0] m32_e, m64_e;
  int          m32_d, m64_d;
  int          busy_n, rdy_n;

  alu_iter_if #(.XLEN(32)) bus32();
  alu_iter_if #(.XLEN(64)) bus64();

  alu_iter #(.XLEN(32), .SHIFT_STEP(4), .ZBB_EN(1'b1)) dut32 (
    .i_clk_n (clk),
    .i_rst   (rst32),
    .bus     (bus32)
  );

  alu_iter #(.XLEN(64), .SHIFT_STEP(64), .ZBB_EN(1'b0)) dut64 (
    .i_clk_n (clk),
    .i_rst   (rst64),
    .bus     (bus64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus32.o_valid === 1'b1) begin
      if (exp_q32.size() == 0) begin
        check_val("spurious_valid32", 64'(exp_q32.size()), 64'd1);
      end else begin
        m32_e = exp_q32.pop_front();
        m32_d = due_q32.pop_front();
        check_val("result32", {32'b0, bus32.o_alu_out}, m32_e);
        check_val("latency32", 64'(cyc), 64'(m32_d));
        last32 = m32_e;
      end
    end
  end

  always @(negedge clk) begin
    if (bus64.o_valid === 1'b1) begin
      if (exp_q64.size() == 0) begin
        check_val("spurious_valid64", 64'(exp_q64.size()), 64'd1);
      end else begin
        m64_e = exp_q64.pop_front();
        m64_d = due_q64.pop_front();
        check_val("result64", bus64.o_alu_out, m64_e);
        check_val("latency64", 64'(cyc), 64'(m64_d));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input bit w, input logic [2:0] f3, input logic [6:0] f7,
                      input bit imm, input bit en, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp, input int lat,
                      input bit push);
    int n = 0;
    while (((w ? bus64.o_ready : bus32.o_ready) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val(w ? "ready64" : "ready32", {63'b0, (w ? bus64.o_ready : bus32.o_ready)}, 64'd1);
    if (w) begin
      bus64.i_valid = 1'b1; bus64.i_funct3 = f3; bus64.i_funct7 = f7;
      bus64.i_alu_imm = imm; bus64.i_alu_en = en; bus64.i_in_a = a; bus64.i_in_b = b;
      if (push) begin exp_q64.push_back(exp); due_q64.push_back(cyc + lat); end
    end else begin
      bus32.i_valid = 1'b1; bus32.i_funct3 = f3; bus32.i_funct7 = f7;
      bus32.i_alu_imm = imm; bus32.i_alu_en = en; bus32.i_in_a = a[31:0]; bus32.i_in_b = b[31:0];
      if (push) begin exp_q32.push_back(exp); due_q32.push_back(cyc + lat); end
    end
    @(negedge clk);
    bus32.i_valid = 1'b0;
    bus64.i_valid = 1'b0;
  endtask

  task automatic op32(input logic [2:0] f3, input logic [6:0] f7, input bit imm,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp, input int lat);
    send(1'b0, f3, f7, imm, 1'b1, a, b, exp, lat, 1'b1);
  endtask

  initial begin
    bus32.i_valid = 0; bus32.i_flush = 0; bus32.i_alu_en = 1; bus32.i_alu_imm = 0;
    bus32.i_funct3 = 0; bus32.i_funct7 = 0; bus32.i_in_a = 0; bus32.i_in_b = 0;
    bus64.i_valid = 0; bus64.i_flush = 0; bus64.i_alu_en = 1; bus64.i_alu_imm = 0;
    bus64.i_funct3 = 0; bus64.i_funct7 = 0; bus64.i_in_a = 0; bus64.i_in_b = 0;
    #1 rst32 = 1'b1; rst64 = 1'b1;
    #2;
    check_val("rst_valid32", {63'b0, bus32.o_valid}, 64'd0);
    check_val("rst_busy32",  {63'b0, bus32.o_busy},  64'd0);
    check_val("rst_out32",   {32'b0, bus32.o_alu_out}, 64'd0);
    check_val("rst_out64",   bus64.o_alu_out, 64'd0);
    @(negedge clk); @(negedge clk);
    rst32 = 1'b0; rst64 = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst32", {63'b0, bus32.o_ready}, 64'd1);
    check_val("ready_after_rst64", {63'b0, bus64.o_ready}, 64'd1);

    // single-cycle ops
    op32(3'b000, 7'b0100000, 0, 5, 7, 64'hFFFFFFFE, 1);
    check_val("sub_ready_stays", {63'b0, bus32.o_ready}, 64'd1);
    send(1'b0, 3'b000, 7'b0100000, 0, 1'b0, 5, 7, 64'd12, 1, 1'b1);  // alu_en=0 forces ADD
    op32(3'b000, 7'b0100000, 1, 5, 7, 64'd12, 1);                  // imm blocks SUB
    op32(3'b000, 7'b0000001, 0, 5, 7, 64'd12, 1);                  // unknown funct7
    op32(3'b010, 7'b0000000, 0, 64'hFFFFFFFF, 1, 64'd1, 1);
    op32(3'b011, 7'b0000000, 0, 64'hFFFFFFFF, 1, 64'd0, 1);
    op32(3'b110, 7'b0000000, 0, 64'hF0, 64'h0F, 64'hFF, 1);
    op32(3'b111, 7'b0000000, 0, 64'hF0F0, 64'hFF00, 64'hF000, 1);
    op32(3'b100, 7'b0000000, 0, 64'hFFFFFFFF, 1, 64'hFFFFFFFE, 1);
    // Zbb
    op32(3'b100, 7'b0000101, 0, 64'hFFFFFFFF, 1, 64'hFFFFFFFF, 1);
    op32(3'b101, 7'b0000101, 0, 64'hFFFFFFFF, 1, 64'd1, 1);
    op32(3'b110, 7'b0000101, 0, 64'hFFFFFFFF, 1, 64'd1, 1);
    op32(3'b111, 7'b0000101, 0, 64'hFFFFFFFF, 1, 64'hFFFFFFFF, 1);
    op32(3'b100, 7'b0000101, 1, 64'hFFFFFFFF, 1, 64'hFFFFFFFE, 1); // imm: no zbb
    // shifts
    op32(3'b001, 7'b0000000, 0, 64'h1234, 64'h20, 64'h1234, 1);   // shamt=0
    op32(3'b001, 7'b0000000, 0, 64'h1234, 64'h24, 64'h12340, 1);  // shamt=4
    op32(3'b101, 7'b0000000, 0, 64'h80000000, 5, 64'h04000000, 2);
    op32(3'b101, 7'b0000001, 0, 64'h80000000, 5, 64'h04000000, 2);
    op32(3'b101, 7'b0100000, 0, 64'h80000000, 31, 64'hFFFFFFFF, 8);
    busy_n = 0; rdy_n = 0;
    for (int k = 0; k < 40 && bus32.o_busy === 1'b1; k++) begin
      busy_n++;
      if (bus32.o_ready === 1'b0) rdy_n++;
      @(negedge clk);
    end
    check_val("sra_busy_cycles",  64'(busy_n), 64'd7);
    check_val("sra_nready_cycles", 64'(rdy_n), 64'd7);
    op32(3'b101, 7'b0000000, 0, 64'h80000000, 31, 64'h1, 8);      // back-to-back
    op32(3'b001, 7'b0000000, 0, 64'h1, 9, 64'h200, 3);

    // flush in the 3rd SHIFT cycle
    send(1'b0, 3'b001, 7'b0, 0, 1'b1, 1, 20, 0, 5, 1'b0);
    @(negedge clk); @(negedge clk);
    bus32.i_flush = 1'b1;
    @(negedge clk);
    bus32.i_flush = 1'b0;
    check_val("flush_valid", {63'b0, bus32.o_valid}, 64'd0);
    check_val("flush_ready", {63'b0, bus32.o_ready}, 64'd1);
    check_val("flush_busy",  {63'b0, bus32.o_busy},  64'd0);
    check_val("flush_hold",  {32'b0, bus32.o_alu_out}, last32);
    repeat (6) @(negedge clk);
    op32(3'b000, 7'b0000000, 0, 3, 4, 64'd7, 1);

    // flush beats a simultaneous valid
    bus32.i_valid = 1'b1; bus32.i_flush = 1'b1; bus32.i_funct3 = 3'b000; bus32.i_funct7 = 7'b0;
    bus32.i_alu_imm = 0; bus32.i_in_a = 32'd9; bus32.i_in_b = 32'd9;
    @(negedge clk);
    bus32.i_valid = 1'b0; bus32.i_flush = 1'b0;
    check_val("flush_vs_valid", {63'b0, bus32.o_valid}, 64'd0);
    repeat (3) @(negedge clk);

    // async reset mid-SRA
    send(1'b0, 3'b101, 7'b0100000, 0, 1'b1, 64'h80000000, 31, 0, 8, 1'b0);
    @(negedge clk);
    #2 rst32 = 1'b1;
    #1;
    check_val("midrst_busy",  {63'b0, bus32.o_busy},  64'd0);
    check_val("midrst_valid", {63'b0, bus32.o_valid}, 64'd0);
    check_val("midrst_out",   {32'b0, bus32.o_alu_out}, 64'd0);
    @(negedge clk);
    rst32 = 1'b0;
    @(negedge clk);
    op32(3'b011, 7'b0000000, 0, 1, 2, 64'd1, 1);

    // 64-bit, single-cycle shifter, no Zbb
    send(1'b1, 3'b100, 7'b0000101, 0, 1'b1, 64'hFFFFFFFF, 1, 64'hFFFFFFFE, 1, 1'b1);
    send(1'b1, 3'b000, 7'b0100000, 0, 1'b1, 5, 7, 64'hFFFFFFFFFFFFFFFE, 1, 1'b1);
    send(1'b1, 3'b101, 7'b0000001, 1, 1'b1, 64'h8000000000000000, 63, 64'd1, 1, 1'b1);
    send(1'b1, 3'b000, 7'b0000000, 0, 1'b1, 10, 20, 64'd30, 1, 1'b1);
    send(1'b1, 3'b101, 7'b0100001, 1, 1'b1, 64'h8000000000000000, 63, 64'hFFFFFFFFFFFFFFFF, 1, 1'b1);
    send(1'b1, 3'b001, 7'b0000000, 1, 1'b1, 1, 64'h68, 64'h0000010000000000, 1, 1'b1);

    repeat (12) @(negedge clk);
    check_val("drain32", 64'(exp_q32.size()), 64'd0);
    check_val("drain64", 64'(exp_q64.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
